// File: rtl/alu.sv
// Signed 16x16 arithmetic unit for the FIR datapath: MUL, ADD, MAC and CLR with
// a single-cycle registered result and one internal running accumulator.
module alu #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               op_sel,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [OUT_W-1:0]  result
);

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_MAC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  op_e                     op;
  logic signed [OUT_W-1:0] a_ext;
  logic signed [OUT_W-1:0] b_ext;
  logic signed [OUT_W-1:0] prod;
  logic signed [OUT_W-1:0] sum;
  logic signed [OUT_W-1:0] mac_sum;
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] acc_next;
  logic signed [OUT_W-1:0] result_next;

  // Operands are sign-extended to full width first so the product is exact
  // and the add cannot overflow; the MAC sum simply wraps modulo 2^OUT_W.
  always_comb begin
    op      = op_e'(op_sel);
    a_ext   = OUT_W'(a);
    b_ext   = OUT_W'(b);
    prod    = a_ext * b_ext;
    sum     = a_ext + b_ext;
    mac_sum = acc + prod;
  end

  always_comb begin
    acc_next    = acc;
    result_next = '0;
    case (op)
      OP_MUL: result_next = prod;
      OP_ADD: result_next = sum;
      OP_MAC: begin
        acc_next    = mac_sum;
        result_next = mac_sum;
      end
      OP_CLR: begin
        acc_next    = '0;
        result_next = '0;
      end
      default: begin
        acc_next    = acc;
        result_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      result <= '0;
    end else begin
      acc    <= acc_next;
      result <= result_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: reset behaviour, MUL/ADD corner cases, MAC chaining,
// wrap, mid-sequence reset, then a short random run against a tracked model.
module tb_alu;

  logic               clk;
  logic               rst;
  logic [1:0]         op_sel;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic signed [31:0] result;

  int n_checks;
  int n_fail;
  int model_acc;
  int exp_val;

  alu #(.DATA_W(16), .OUT_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .op_sel (op_sel),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expected);
    n_checks++;
    assert (result === expected)
    else begin
      n_fail++;
      $error("FAIL %s: result=%h expected=%h", tag, result, expected);
    end
  endtask

  // Drive one op, let it be captured on the next rising edge, sample 1 ns later.
  task automatic step(input logic [1:0] op, input logic signed [15:0] av,
                      input logic signed [15:0] bv, input string tag,
                      input logic [31:0] expected);
    op_sel = op;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    op_sel   = 2'b00;
    a        = 16'sd5;
    b        = 16'sd7;

    #1;
    check("reset_t0", 32'h0000_0000);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold", 32'h0000_0000);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_mul", 32'd35);

    step(2'b00,  16'sd3,      -16'sd4,     "mul_3_m4",      32'hFFFF_FFF4);
    step(2'b00, -16'sd32768, -16'sd32768,  "mul_min_min",   32'h4000_0000);
    step(2'b01,  16'sd32767,  16'sd1,      "add_max_1",     32'h0000_8000);
    step(2'b01, -16'sd32768, -16'sd1,      "add_min_m1",    32'hFFFF_7FFF);

    step(2'b10,  16'sd2,  16'sd3, "mac_2_3",      32'd6);
    step(2'b10,  16'sd4,  16'sd5, "mac_4_5",      32'd26);
    step(2'b00,  16'sd1,  16'sd1, "mul_interleave", 32'd1);
    step(2'b10, -16'sd6,  16'sd1, "mac_m6_1",     32'd20);
    step(2'b11,  16'sd9,  16'sd9, "clr",          32'd0);

    step(2'b10, -16'sd32768, -16'sd32768, "mac_wrap_1", 32'h4000_0000);
    step(2'b10, -16'sd32768, -16'sd32768, "mac_wrap_2", 32'h8000_0000);
    step(2'b10,  16'sd1,      16'sd1,     "mac_wrap_3", 32'h8000_0001);

    // Asynchronous reset mid-sequence: clears without a clock edge.
    op_sel = 2'b10;
    a      = 16'sd7;
    b      = 16'sd7;
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_mid_mac", 32'h0000_0000);
    @(posedge clk);
    #1;
    check("async_reset_hold", 32'h0000_0000);
    rst = 1'b1;
    step(2'b10, 16'sd2, 16'sd3, "mac_after_reset", 32'd6);

    model_acc = 6;
    for (int i = 0; i < 64; i++) begin
      logic [1:0]         rop;
      logic signed [15:0] ra;
      logic signed [15:0] rb;
      rop = 2'($urandom_range(0, 2));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      case (rop)
        2'b00: exp_val = int'(ra) * int'(rb);
        2'b01: exp_val = int'(ra) + int'(rb);
        default: begin
          model_acc = model_acc + int'(ra) * int'(rb);
          exp_val   = model_acc;
        end
      endcase
      step(rop, ra, rb, "random", exp_val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
